// File: rtl/act_ingress_scheduler_pkg.sv
// Shared definitions for the activation ingress scheduler.
// ARRAY_ROWS : rows of the systolic array. It sets the skew depth of the last
//              row and the drain length after each accepted beat.
// POS_WIDTH  : width of the frame position count and index.
// sched_state_t : scheduler states, which sequence flush/accept/drain per position.
package act_ingress_scheduler_pkg;

  localparam int ARRAY_ROWS = 8;
  localparam int POS_WIDTH  = 16;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    ACCEPT,
    DRAIN,
    DONE,
    ABORT_FLUSH
  } sched_state_t;

endpackage

// File: rtl/act_ingress_scheduler.sv
// Activation ingress scheduler.
// For every spatial position of a frame, the scheduler does the following:
//   1. It flushes the ingress for one cycle.
//   2. It opens the accept window for exactly one AXI beat.
//   3. It keeps the ingress enabled until the skew wavefront has drained into
//      the west boundary of the array.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   start, abort      frame control pulses from the top-level FSM
//   num_pos           positions in the frame, latched on start
//   stall             array back-pressure; freezes ingress shifting
//   s_axis_tvalid/tready/tlast  monitored AXI handshake and framing
//   ing_enable/accept/flush     ingress controls
//   pos_idx           current position index
//   busy, done        activity flag; one-cycle completion pulse
//   frame_err         sticky TLAST framing error
module act_ingress_scheduler #(
  parameter int ARRAY_ROWS = act_ingress_scheduler_pkg::ARRAY_ROWS,
  parameter int POS_WIDTH  = act_ingress_scheduler_pkg::POS_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [POS_WIDTH-1:0] num_pos,
  input  logic                 stall,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic                 ing_enable,
  output logic                 ing_accept,
  output logic                 ing_flush,
  output logic [POS_WIDTH-1:0] pos_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 frame_err
);

  import act_ingress_scheduler_pkg::*;

  localparam int CNT_W = (ARRAY_ROWS > 1) ? $clog2(ARRAY_ROWS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ARRAY_ROWS - 1);

  sched_state_t         state_q, state_d;
  logic [POS_WIDTH-1:0] numPos_q, numPos_d;
  logic [POS_WIDTH-1:0] posIdx_q, posIdx_d;
  logic [CNT_W-1:0]     drainCnt_q, drainCnt_d;
  logic                 frameErr_q, frameErr_d;
  logic                 hs;
  logic                 lastPos;

  assign hs      = s_axis_tvalid && s_axis_tready;
  // numPos_q is never zero inside a frame, so the subtraction cannot underflow.
  assign lastPos = (posIdx_q == (numPos_q - POS_WIDTH'(1)));

  assign pos_idx   = posIdx_q;
  assign frame_err = frameErr_q;

  // State and datapath registers. Reset returns everything to an idle,
  // all-zero condition so that the next start re-flushes the ingress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      numPos_q   <= '0;
      posIdx_q   <= '0;
      drainCnt_q <= '0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      numPos_q   <= numPos_d;
      posIdx_q   <= posIdx_d;
      drainCnt_q <= drainCnt_d;
      frameErr_q <= frameErr_d;
    end
  end

  // Next-state logic.
  // Abort takes priority over the handshake, so a beat that arrives together
  // with an abort is discarded by the exit flush. The drain count advances
  // only in unstalled cycles. The terminal count is honoured only when the
  // array is not stalled, which holds the last row until it can take data.
  always_comb begin
    state_d    = state_q;
    numPos_d   = numPos_q;
    posIdx_d   = posIdx_q;
    drainCnt_d = drainCnt_q;
    frameErr_d = frameErr_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          numPos_d   = num_pos;
          posIdx_d   = '0;
          drainCnt_d = '0;
          frameErr_d = 1'b0;
          state_d    = (num_pos == '0) ? DONE : FLUSH;
        end
      end
      FLUSH: begin
        state_d = abort ? ABORT_FLUSH : ACCEPT;
      end
      ACCEPT: begin
        if (abort) begin
          state_d = ABORT_FLUSH;
        end else if (hs) begin
          state_d    = DRAIN;
          drainCnt_d = '0;
          if (s_axis_tlast != lastPos) begin
            frameErr_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = ABORT_FLUSH;
        end else if (!stall) begin
          if (drainCnt_q == CNT_LAST) begin
            if (lastPos) begin
              state_d = DONE;
            end else begin
              posIdx_d = posIdx_q + POS_WIDTH'(1);
              state_d  = FLUSH;
            end
          end else begin
            drainCnt_d = drainCnt_q + CNT_W'(1);
          end
        end
      end
      DONE:        state_d = IDLE;
      ABORT_FLUSH: state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Output decode. Accept is driven only together with enable, and both
  // drop under stall, so the ingress never takes a beat it cannot shift.
  always_comb begin
    ing_enable = 1'b0;
    ing_accept = 1'b0;
    ing_flush  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
      end
      FLUSH, ABORT_FLUSH: begin
        ing_flush = 1'b1;
        busy      = 1'b1;
      end
      ACCEPT: begin
        ing_enable = !stall;
        ing_accept = !stall;
        busy       = 1'b1;
      end
      DRAIN: begin
        ing_enable = !stall;
        busy       = 1'b1;
      end
      DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_act_ingress_scheduler.sv
// Randomized self-checking bench for act_ingress_scheduler.
// Each frame is walked as a sequence of positions. For every position, the
// bench expects one flush cycle, an accept window that stays open until a
// handshake, and ARRAY_ROWS unstalled drain cycles. Expected outputs come
// from that frame walk, not from a state machine.
module tb_act_ingress_scheduler;

  localparam int ROWS = act_ingress_scheduler_pkg::ARRAY_ROWS;
  localparam int PW   = act_ingress_scheduler_pkg::POS_WIDTH;

  logic          clk = 1'b0;
  logic          rst, start, abort, stall, tvalid, tready, tlast;
  logic [PW-1:0] numPos;
  logic          ingEnable, ingAccept, ingFlush, busy, done, frameErr;
  logic [PW-1:0] posIdx;

  int errCount   = 0;
  int checkCount = 0;
  int frameCycle = 0;
  bit expErr     = 1'b0;
  int expPos     = 0;

  always #5 clk = ~clk;

  act_ingress_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .num_pos      (numPos),
    .stall        (stall),
    .s_axis_tvalid(tvalid),
    .s_axis_tready(tready),
    .s_axis_tlast (tlast),
    .ing_enable   (ingEnable),
    .ing_accept   (ingAccept),
    .ing_flush    (ingFlush),
    .pos_idx      (posIdx),
    .busy         (busy),
    .done         (done),
    .frame_err    (frameErr)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Compares the control outputs as one vector, followed by the position index.
  task automatic expectOutputs(input string tag, input bit en, input bit acc,
                               input bit fl, input bit bz, input bit dn);
    checkOutput(tag, {26'd0, ingEnable, ingAccept, ingFlush, busy, done, frameErr},
                {26'd0, en, acc, fl, bz, dn, expErr});
    checkOutput({tag, "_pos"}, 32'(posIdx), 32'(expPos));
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit a, input bit sl,
                               input bit tv, input bit tr, input bit tl);
    rst = r; start = s; abort = a; stall = sl;
    tvalid = tv; tready = tr; tlast = tl;
  endtask

  function automatic bit rnd(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Closes one in-frame cycle and handles any abort or reset issued in that cycle.
  task automatic endCycle(input bit ab, input bit rs, output bit quit);
    step();
    frameCycle++;
    quit = ab || rs;
    if (rs) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      expErr = 1'b0;
      expPos = 0;
      #1 expectOutputs("after_reset", 0, 0, 0, 0, 0);
    end else if (ab) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      #1 expectOutputs("abort_flush", 0, 0, 1, 1, 0);
      step();
      #1 expectOutputs("abort_idle", 0, 0, 0, 0, 0);
    end
  endtask

  // Runs one frame. abortAt/rstAt are in-frame cycle numbers (-1 = never).
  // badPos selects a position whose TLAST is inverted.
  task automatic runFrame(input int n, input int stallPct, input int validPct,
                          input int abortAt, input int rstAt, input int badPos);
    bit quit, ab, rs, st, tv, tr, tl, hs, isLast;
    int cnt, guard;
    numPos = PW'(n);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    #1 expectOutputs("idle_start", 0, 0, 0, 0, 0);
    step();
    expErr     = 1'b0;
    expPos     = 0;
    frameCycle = 0;
    if (n == 0) begin
      applyStimulus(0, 0, 0, 0, 1, 1, 0);
      #1 expectOutputs("zero_done", 0, 0, 0, 1, 1);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      #1 expectOutputs("zero_idle", 0, 0, 0, 0, 0);
      return;
    end
    for (int p = 0; p < n; p++) begin
      expPos = p;
      isLast = (p == n - 1);
      ab = (frameCycle == abortAt);
      rs = (frameCycle == rstAt);
      st = rnd(stallPct);
      applyStimulus(rs, rnd(30), ab, st, rnd(50), rnd(50), rnd(50));
      #1 if (!rs) expectOutputs("flush", 0, 0, 1, 1, 0);
      endCycle(ab, rs, quit);
      if (quit) return;
      hs = 1'b0;
      guard = 0;
      while (!hs) begin
        ab = (frameCycle == abortAt);
        rs = (frameCycle == rstAt);
        st = rnd(stallPct);
        tv = rnd(validPct);
        tr = !st && rnd(validPct);
        tl = isLast ^ (p == badPos);
        applyStimulus(rs, rnd(30), ab, st, tv, tr, tl);
        #1 if (!rs) expectOutputs("accept", !st, !st, 0, 1, 0);
        hs = tv && tr;
        endCycle(ab, rs, quit);
        if (quit) return;
        if (hs && (tl != isLast)) expErr = 1'b1;
        guard++;
        if (!hs && guard > 400) begin
          checkOutput("accept_timeout", 32'(guard), 32'd0);
          return;
        end
      end
      cnt = 0;
      while (cnt < ROWS) begin
        ab = (frameCycle == abortAt);
        rs = (frameCycle == rstAt);
        st = rnd(stallPct);
        applyStimulus(rs, rnd(30), ab, st, rnd(50), !st && rnd(50), rnd(50));
        #1 if (!rs) expectOutputs("drain", !st, 0, 0, 1, 0);
        endCycle(ab, rs, quit);
        if (quit) return;
        if (!st) cnt++;
      end
    end
    applyStimulus(0, rnd(50), rnd(50), rnd(50), rnd(50), rnd(50), rnd(50));
    #1 expectOutputs("done", 0, 0, 0, 1, 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1 expectOutputs("idle_after", 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, ab, rs;
    numPos = '0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1 expectOutputs("reset", 0, 0, 0, 0, 0);

    runFrame(3, 0, 100, -1, -1, -1);
    runFrame(2, 40, 100, -1, -1, -1);
    runFrame(4, 0, 100, -1, -1, 1);
    runFrame(5, 0, 100, 21, -1, -1);
    runFrame(0, 0, 100, -1, -1, -1);
    runFrame(3, 0, 100, -1, 14, -1);
    runFrame(1, 0, 100, -1, -1, -1);

    for (int i = 0; i < 30; i++) begin
      n  = int'($urandom_range(6));
      ab = rnd(20) ? int'($urandom_range(60)) : -1;
      rs = rnd(10) ? int'($urandom_range(60)) : -1;
      runFrame(n, int'($urandom_range(50)), 30 + int'($urandom_range(70)), ab, rs,
               int'($urandom_range(n)));
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
